// File: rtl/tube_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tube_pkg
//  Description : Shared types and constants for the 8-digit 7-segment scan
//                controller: all-off pin levels, digit record, state encoding
//                and the hex-to-segment decode table.
//  Revision    : 1.0 - initial release
// ============================================================================
package tube_pkg;

    // All-off levels for the active-low segment and digit pins
    localparam logic [7:0] SEG_OFF = 8'hff;
    localparam logic [7:0] DIG_OFF = 8'hff;

    // One displayed digit: hex nibble plus decimal point (1 = lit)
    typedef struct packed {
        logic [3:0] val;
        logic       dp;
    } digit_t;

    // Scan FSM: dead time before each digit, then the lit period
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Active-low {g,f,e,d,c,b,a} patterns, entry i is hex digit i
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage : tube_pkg
`default_nettype wire

// File: rtl/tube_seg_dec.sv
`default_nettype none
// ============================================================================
//  Module      : tube_seg_dec
//  Description : Combinational hex nibble to active-low 7-segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tube_seg_dec
    import tube_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    // Straight table lookup; bit order {g,f,e,d,c,b,a}
    assign seg = SEG_TABLE[val];

endmodule : tube_seg_dec
`default_nettype wire

// File: rtl/tube_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tube_scan_ctrl
//  Description : Time-multiplexed scan controller for an 8-digit common-anode
//                7-segment display. Host writes land in a shadow buffer that
//                is copied to the displayed buffer only at the frame wrap, so
//                a frame never shows a half-updated set of digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tube_scan_ctrl
    import tube_pkg::*;
#(
    parameter int N_DIG     = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic [7:0] en_mask,
    output logic [7:0] LED7S,
    output logic [7:0] dig,
    output logic       frame_tick
);

    // Counter must hold the longer of the two state durations
    localparam int               CNT_MAX    = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int               CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
    localparam logic [2:0]       IDX_LAST   = 3'(N_DIG - 1);
    localparam logic [3:0]       N_DIG_V    = 4'(N_DIG);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;

    // Buffers are always 8 deep; entries at or above N_DIG are never written
    digit_t           shadow [8];
    digit_t           active [8];
    logic             pending;

    logic             show_done;
    logic             wrap;
    logic             wr_hit;
    digit_t           cur;
    logic [6:0]       cur_seg;

    assign show_done  = (state == ST_SHOW) && (cnt == SHOW_LAST);
    assign wrap       = show_done && (idx == IDX_LAST);
    assign wr_hit     = wr_en && ({1'b0, wr_addr} < N_DIG_V);
    assign cur        = active[idx];
    assign frame_tick = wrap;

    tube_seg_dec u_seg_dec (
        .val (cur.val),
        .seg (cur_seg)
    );

    // Scan FSM, dwell counter, digit index and registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= '0;
            LED7S <= SEG_OFF;
            dig   <= DIG_OFF;
        end else begin
            case (state)
                ST_BLANK: begin
                    LED7S <= SEG_OFF;
                    dig   <= DIG_OFF;
                    // Zero dead time passes straight through to SHOW
                    if ((BLANK_CYC == 0) || (cnt == BLANK_LAST)) begin
                        state <= ST_SHOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    // Segments always drive; the mask only gates the digit enable
                    LED7S <= {~cur.dp, cur_seg};
                    dig   <= en_mask[idx] ? ~(8'h01 << idx) : DIG_OFF;
                    if (show_done) begin
                        idx   <= wrap ? 3'd0 : idx + 1'b1;
                        cnt   <= '0;
                        state <= (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Host writes into shadow; shadow published to active at the frame wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            pending <= 1'b0;
        end else begin
            // Non-blocking copy takes the pre-write shadow on a write-at-wrap
            if (wrap && pending) begin
                for (int i = 0; i < 8; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_hit) begin
                shadow[wr_addr] <= {wr_data, wr_dp};
                pending         <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

endmodule : tube_scan_ctrl
`default_nettype wire

// File: tb/tb_tube_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tube_scan_ctrl
//  Description : Scoreboard bench for tube_scan_ctrl. A frame-position model
//                predicts pins per cycle; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tube_scan_ctrl;

    localparam int SLOT  = 5;           // 1 blank + 4 lit cycles per digit
    localparam int FRAME = 8 * SLOT;    // 40 cycles
    localparam int FRAME6 = 6 * SLOT;   // 30 cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [3:0] wr_data = 4'd0;
    logic       wr_dp = 1'b0;
    logic [7:0] en_mask = 8'hff;
    logic [7:0] led, dig, led6, dig6;
    logic       ft, ft6;

    always #5 clk = ~clk;

    tube_scan_ctrl #(.N_DIG(8), .SCAN_DIV(4), .BLANK_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_dp(wr_dp), .en_mask(en_mask),
        .LED7S(led), .dig(dig), .frame_tick(ft)
    );

    tube_scan_ctrl #(.N_DIG(6), .SCAN_DIV(4), .BLANK_CYC(1)) dut6 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_dp(wr_dp), .en_mask(en_mask),
        .LED7S(led6), .dig(dig6), .frame_tick(ft6)
    );

    typedef struct {
        logic [7:0] led;
        logic [7:0] dig;
        logic       ft;
        logic       ft6;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference segment patterns indexed by hex value
    logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: what the host has written and what the current frame displays
    logic [3:0] m_sh_val [8];
    logic       m_sh_dp  [8];
    logic [3:0] m_act_val[8];
    logic       m_act_dp [8];
    int         pos  = 0;   // position of the current cycle within the frame
    int         pos6 = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Predict the pins of the next cycle from this cycle's frame position
    task automatic model_step();
        exp_t e;
        int   slot, sub;
        if (!rst_n) begin
            e.led = 8'hff; e.dig = 8'hff; e.ft = 1'b0; e.ft6 = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_sh_val[i] = 4'd0; m_sh_dp[i] = 1'b0;
                m_act_val[i] = 4'd0; m_act_dp[i] = 1'b0;
            end
            pos = 0; pos6 = 0;
        end else begin
            slot = pos / SLOT;
            sub  = pos % SLOT;
            if (sub == 0) begin
                e.led = 8'hff; e.dig = 8'hff;
            end else begin
                e.led = {~m_act_dp[slot], seg_lut[m_act_val[slot]]};
                e.dig = en_mask[slot] ? ~(8'h01 << slot) : 8'hff;
            end
            if (pos == FRAME - 1) begin
                for (int i = 0; i < 8; i++) begin
                    m_act_val[i] = m_sh_val[i]; m_act_dp[i] = m_sh_dp[i];
                end
            end
            if (wr_en) begin
                m_sh_val[wr_addr] = wr_data; m_sh_dp[wr_addr] = wr_dp;
            end
            pos  = (pos + 1) % FRAME;
            pos6 = (pos6 + 1) % FRAME6;
            e.ft  = (pos == FRAME - 1);
            e.ft6 = (pos6 == FRAME6 - 1);
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic we, input logic [2:0] a,
                         input logic [3:0] d, input logic p, input logic [7:0] m);
        @(negedge clk);
        rst_n = r; wr_en = we; wr_addr = a; wr_data = d; wr_dp = p; en_mask = m;
        model_step();
    endtask

    // Monitor: one prediction per cycle, sampled after the active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("LED7S", led, e.led);
                chk("dig", dig, e.dig);
                chk("frame_tick", {7'd0, ft}, {7'd0, e.ft});
                chk("frame_tick_n6", {7'd0, ft6}, {7'd0, e.ft6});
                chk("dig_hi_n6", {6'd0, dig6[7:6]}, 8'h03);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mask;
        logic       we, dp, wrap_wr_done;
        logic [2:0] a;
        logic [3:0] d;
        mask = 8'hff;
        wrap_wr_done = 1'b0;

        // Reset held, then released; direct check of reset pins
        cycle(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, mask);
        #1;
        chk("reset_LED7S", led, 8'hff);
        chk("reset_dig", dig, 8'hff);
        chk("reset_frame_tick", {7'd0, ft}, 8'h00);
        cycle(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, mask);

        // Mid-frame writes of digits 0 and 1, then idle two frames
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k == 10)      cycle(1'b1, 1'b1, 3'd0, 4'h3, 1'b0, mask);
            else if (k == 11) cycle(1'b1, 1'b1, 3'd1, 4'hA, 1'b1, mask);
            else              cycle(1'b1, 1'b0, 3'd0, 4'h0, 1'b0, mask);
        end

        // Masked digit 2, then randomized writes and masks
        mask = 8'hfb;
        for (int k = 0; k < 600; k++) begin
            we = ($urandom_range(0, 3) == 0);
            a  = 3'($urandom_range(0, 7));
            d  = 4'($urandom_range(0, 15));
            dp = 1'($urandom_range(0, 1));
            if (k > 60 && (k % 50) == 0) begin
                case ($urandom_range(0, 2))
                    0:       mask = 8'hfb;
                    1:       mask = 8'hff;
                    default: mask = 8'($urandom_range(0, 255));
                endcase
            end
            if (pos == FRAME - 1 && k > 100 && !wrap_wr_done) begin
                we = 1'b1; a = 3'd5; d = 4'h7; dp = 1'b0;
                wrap_wr_done = 1'b1;
            end
            cycle(1'b1, we, a, d, dp, mask);
        end

        // Run to SHOW of digit 4 and reset mid-scan
        mask = 8'hff;
        for (int k = 0; k < FRAME && pos != 4 * SLOT + 3; k++)
            cycle(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, mask);
        chk("pre_reset_dig", dig, 8'hef);
        cycle(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, mask);
        #1;
        chk("midscan_reset_LED7S", led, 8'hff);
        chk("midscan_reset_dig", dig, 8'hff);
        cycle(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, mask);

        // Restart from digit 0 with cleared buffers, then more random traffic
        for (int k = 0; k < 200; k++) begin
            we = ($urandom_range(0, 5) == 0);
            a  = 3'($urandom_range(0, 7));
            d  = 4'($urandom_range(0, 15));
            dp = 1'($urandom_range(0, 1));
            cycle(1'b1, we, a, d, dp, mask);
        end

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tube_scan_ctrl
`default_nettype wire
